ntp_uart_responder: RTL and testbench
=====================================

# ntp_uart_responder

Serial-link NTP server: the responder end of the clock's 48-byte NTP exchange. It sits between `uart_rx`/`uart_tx` byte streams and the clock's local-time counter. It collects a 48-byte NTP client request and validates it. It then transmits a 48-byte mode-4 server reply whose timestamps are derived from the clock's current local time. This lets one board act as a time source for another running the internet time-set sequence.

## Interface
- `CLK_FRE`, 50, clock frequency in MHz.
- `GAP_TIMEOUT_MS`, 2, inter-byte idle time that aborts a partial request frame.
- `UTC_OFFSET`, 28800, local-time offset from UTC in seconds (UTC+8).
- `STRATUM`, 1, value placed in reply byte 1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low; one clock.
- `local_time`  in  32  local seconds since 1970-01-01 00:00 local time.
- `time_valid`  in  1  `local_time` is trustworthy; requests are rejected while low.
- `rx_data`  in  8  received byte from `uart_rx`.
- `rx_data_valid`  in  1  `rx_data` is valid this cycle.
- `rx_data_ready`  out  1  constant 1.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_valid`  out  1  `tx_data` is valid.
- `tx_data_ready`  in  1  `uart_tx` accepts the byte.
- `busy`  out  1  high while in CHECK or SEND.
- `served`  out  1  one-cycle pulse after the last reply byte is accepted.
- `req_count`  out  16  replies served; wraps from 65535 to 0.
- `rej_count`  out  8  requests rejected or truncated; wraps.

## Operation
- States:
  - COLLECT: receives the request; `rx_idx` 0..47.
  - CHECK: validates the frame and snapshots time (one cycle).
  - SEND: transmits the reply; `tx_idx` 0..47.
- In COLLECT, each `rx_data_valid` byte is accepted at position `rx_idx`, which then increments.
  - Only byte 0, byte 2 and bytes 40..47 are stored (10 bytes). Other bytes are discarded.
- The 48th byte moves the block to CHECK.
- CHECK accepts the frame if byte0[2:0]==3 and `time_valid`==1.
  - On accept: latch `ntp_sec = local_time - UTC_OFFSET + 2208988800`, computed mod 2^32 with 32-bit wrap. Then go to SEND.
  - On reject: `rej_count`+1, `rx_idx`<=0, return to COLLECT.
- Gap timer: counts cycles since the last accepted byte while `rx_idx`>0.
  - At `CLK_FRE*1000*GAP_TIMEOUT_MS` cycles: `rx_idx`<=0, `rej_count`+1.
  - If a byte arrives in the cycle the timer expires, the byte wins: it is stored at the current `rx_idx` and the timer restarts.
- Reply bytes:
  - 0: {2'b00, req byte0[5:3], 3'd4}.
  - 1: `STRATUM`.
  - 2: req byte 2.
  - 3: 8'hEC.
  - 4..11: 0.
  - 12..15: "LOCL".
  - 16..19: `ntp_sec`, big-endian; 20..23: 0.
  - 24..31: req bytes 40..47, in order.
  - 32..35: `ntp_sec`; 36..39: 0.
  - 40..43: `ntp_sec`; 44..47: 0.
- Bytes arriving during CHECK or SEND are dropped and are not counted.
- After the last reply byte: `served` pulses, `req_count`+1, `rx_idx`<=0, gap timer cleared, return to COLLECT.

## Timing
- Reset values:
  - `tx_data`=0, `tx_data_valid`=0, `busy`=0, `served`=0, `req_count`=0, `rej_count`=0.
  - State COLLECT, `rx_idx`=0.
  - `rx_data_ready`=1.
- Reset asserted mid-frame or mid-SEND aborts immediately. The partial reply is not resumed.
- The edge that accepts byte 47 enters CHECK. The next edge enters SEND with `tx_data`=reply[0] and `tx_data_valid`=1, 2 cycles after the last `rx_data_valid`.
- A transfer happens on an edge where `tx_data_valid`&&`tx_data_ready`.
  - `tx_data_valid` stays high between bytes, and `tx_data` advances to the next byte on that same edge.
  - While `tx_data_ready`=0, `tx_data` and `tx_data_valid` are held stable.
- On the transfer of byte 47, `tx_data_valid`<=0 and `served`=1 for exactly one cycle.
- `ntp_sec` is frozen in CHECK. A `local_time` change during SEND does not alter the reply.

## Test plan
- Reset: hold `reset_n`=0 with random inputs -> every output at its reset value, `rx_data_ready`=1.
- Valid request: byte0=0xDB, bytes 40..47=01..08, others 0, `local_time`=0x66DE0000, `time_valid`=1, `tx_data_ready`=1 ->
  - 48 bytes out, byte0=0x1C, byte3=0xEC.
  - Bytes 24..31=01..08.
  - Bytes 32..35=EA 88 0E 00.
  - `served` pulses once and `req_count`=1.
- Backpressure: drop `tx_data_ready` for 10 cycles while byte 5 is presented -> `tx_data` and `tx_data_valid` are unchanged, and the full frame is still correct.
- Reject:
  - byte0=0x1C -> no `tx_data_valid`, `rej_count`=1.
  - Valid frame sent with `time_valid`=0 -> `rej_count`=2.
- Gap abort: send 20 bytes, idle for more than the timeout, then a valid 48-byte request -> exactly one reply, `rej_count`=1.
- Wrap and reset:
  - `local_time`=0x80000000 -> bytes 32..35=03 AA 0E 00.
  - Assert `reset_n` during byte 20 of a reply -> `tx_data_valid` falls at once; the next valid request gets a full reply.

Source files
------------

// File: rtl/ntp_uart_responder.sv
// rtl/ntp_uart_responder.sv - NTP server over a UART byte stream: collects a 48-byte request, replies in mode 4
module ntp_uart_responder #(
    parameter int CLK_FRE        = 50,
    parameter int GAP_TIMEOUT_MS = 2,
    parameter int UTC_OFFSET     = 28800,
    parameter int STRATUM        = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] local_time,
    input  logic        time_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        busy,
    output logic        served,
    output logic [15:0] req_count,
    output logic [7:0]  rej_count
);
    localparam logic [31:0] GAP_LAST  = 32'(CLK_FRE * 1000 * GAP_TIMEOUT_MS - 1);
    // Unix-local to NTP era 0: remove the zone offset, add 70 years of seconds.
    localparam logic [31:0] SEC_ADJ   = 32'd2208988800 - 32'(UTC_OFFSET);
    localparam logic [7:0]  STRATUM_B = 8'(STRATUM);

    typedef enum logic [1:0] {COLLECT, CHECK, SEND} state_t;

    state_t      state, state_nxt;
    logic [5:0]  rx_idx;
    logic [5:0]  tx_idx;
    logic [5:0]  req_mode;
    logic [7:0]  req_b2;
    logic [7:0]  req_ts [8];
    logic [31:0] ntp_sec;
    logic [31:0] gap_cnt;
    logic [7:0]  reply_byte;
    logic        frame_ok;

    assign rx_data_ready = 1'b1;
    assign frame_ok      = (req_mode[2:0] == 3'd3) && time_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (rx_data_valid && rx_idx == 6'd47) state_nxt = CHECK;
            CHECK:   state_nxt = frame_ok ? SEND : COLLECT;
            SEND:    if (tx_data_ready && tx_idx == 6'd47) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            CHECK: busy = 1'b1;
            SEND: begin
                busy          = 1'b1;
                tx_data_valid = 1'b1;
                tx_data       = reply_byte;
            end
            default: ;
        endcase
    end

    always_comb begin
        reply_byte = 8'h00;
        case (tx_idx)
            6'd0:                       reply_byte = {2'b00, req_mode[5:3], 3'd4};
            6'd1:                       reply_byte = STRATUM_B;
            6'd2:                       reply_byte = req_b2;
            6'd3:                       reply_byte = 8'hEC;
            6'd12, 6'd15:               reply_byte = 8'h4C;
            6'd13:                      reply_byte = 8'h4F;
            6'd14:                      reply_byte = 8'h43;
            6'd16, 6'd32, 6'd40:        reply_byte = ntp_sec[31:24];
            6'd17, 6'd33, 6'd41:        reply_byte = ntp_sec[23:16];
            6'd18, 6'd34, 6'd42:        reply_byte = ntp_sec[15:8];
            6'd19, 6'd35, 6'd43:        reply_byte = ntp_sec[7:0];
            6'd24, 6'd25, 6'd26, 6'd27,
            6'd28, 6'd29, 6'd30, 6'd31: reply_byte = req_ts[tx_idx[2:0]];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_idx    <= 6'd0;
            tx_idx    <= 6'd0;
            req_mode  <= 6'd0;
            req_b2    <= 8'h00;
            for (int i = 0; i < 8; i++) req_ts[i] <= 8'h00;
            ntp_sec   <= 32'd0;
            gap_cnt   <= 32'd0;
            served    <= 1'b0;
            req_count <= 16'd0;
            rej_count <= 8'd0;
        end else begin
            served <= 1'b0;
            case (state)
                COLLECT: begin
                    // A byte landing on the expiry cycle takes priority over the abort.
                    if (rx_data_valid) begin
                        gap_cnt <= 32'd0;
                        rx_idx  <= (rx_idx == 6'd47) ? 6'd0 : rx_idx + 6'd1;
                        if (rx_idx == 6'd0)  req_mode <= rx_data[5:0];
                        if (rx_idx == 6'd2)  req_b2   <= rx_data;
                        if (rx_idx >= 6'd40) req_ts[rx_idx[2:0]] <= rx_data;
                    end else if (rx_idx != 6'd0) begin
                        if (gap_cnt == GAP_LAST) begin
                            rx_idx    <= 6'd0;
                            gap_cnt   <= 32'd0;
                            rej_count <= rej_count + 8'd1;
                        end else begin
                            gap_cnt <= gap_cnt + 32'd1;
                        end
                    end
                end
                CHECK: begin
                    tx_idx  <= 6'd0;
                    gap_cnt <= 32'd0;
                    if (frame_ok) begin
                        ntp_sec <= local_time + SEC_ADJ;
                    end else begin
                        rej_count <= rej_count + 8'd1;
                    end
                end
                SEND: begin
                    if (tx_data_ready) begin
                        if (tx_idx == 6'd47) begin
                            tx_idx    <= 6'd0;
                            served    <= 1'b1;
                            req_count <= req_count + 16'd1;
                        end else begin
                            tx_idx <= tx_idx + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ntp_uart_responder.sv
// tb/tb_ntp_uart_responder.sv - directed self-checking bench for ntp_uart_responder
module tb_ntp_uart_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] local_time;
    logic        time_valid;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        busy;
    logic        served;
    logic [15:0] req_count;
    logic [7:0]  rej_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] req   [48];
    logic [7:0] rsp   [48];
    logic [7:0] exp_b [48];

    always #5 clk = ~clk;

    ntp_uart_responder #(
        .CLK_FRE(1), .GAP_TIMEOUT_MS(1), .UTC_OFFSET(28800), .STRATUM(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .local_time(local_time), .time_valid(time_valid),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .busy(busy), .served(served), .req_count(req_count), .rej_count(rej_count)
    );

    task automatic do_reset();
        reset_n = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h00; tx_data_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic make_req(input logic [7:0] b0, input logic [7:0] b2);
        foreach (req[i]) req[i] = 8'h00;
        req[0] = b0;
        req[2] = b2;
        for (int i = 0; i < 8; i++) req[40+i] = 8'(i + 1);
    endtask

    task automatic build_exp(input logic [7:0] b0, input logic [31:0] sec);
        foreach (exp_b[i]) exp_b[i] = 8'h00;
        exp_b[0] = b0; exp_b[1] = 8'd1; exp_b[2] = req[2]; exp_b[3] = 8'hEC;
        exp_b[12] = 8'h4C; exp_b[13] = 8'h4F; exp_b[14] = 8'h43; exp_b[15] = 8'h4C;
        for (int k = 0; k < 4; k++) begin
            exp_b[16+k] = sec[31-8*k -: 8];
            exp_b[32+k] = sec[31-8*k -: 8];
            exp_b[40+k] = sec[31-8*k -: 8];
        end
        for (int i = 0; i < 8; i++) exp_b[24+i] = req[40+i];
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            rx_data = req[i]; rx_data_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_data_valid = 1'b0;
    endtask

    task automatic recv_frame(input int start, input int stop, output int n);
        int budget;
        budget = 0;
        n = start;
        tx_data_ready = 1'b1;
        while (n < stop && budget < 400) begin
            if (tx_data_valid && tx_data_ready) begin
                rsp[n] = tx_data;
                n++;
            end
            @(posedge clk); #1;
            budget++;
        end
    endtask

    task automatic watch_quiet(input int cycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (tx_data_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rx_data = 8'($urandom); rx_data_valid = 1'($urandom); tx_data_ready = 1'($urandom);
            local_time = $urandom; time_valid = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (tx_data !== 8'h00 || tx_data_valid !== 1'b0 || busy !== 1'b0 || served !== 1'b0 ||
                req_count !== 16'd0 || rej_count !== 8'd0 || rx_data_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_values: tx_data=%h valid=%b busy=%b served=%b req=%0d rej=%0d ready=%b, expected 00 0 0 0 0 0 1",
                         tx_data, tx_data_valid, busy, served, req_count, rej_count, rx_data_ready);
            end
        end
        rx_data_valid = 1'b0; tx_data_ready = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_valid();
        int n;
        do_reset();
        local_time = 32'h66DE0000; time_valid = 1'b1;
        make_req(8'hDB, 8'h00);
        build_exp(8'h1C, 32'hEA880E00);
        send_bytes(0, 48);
        n_checks++;
        if (tx_data_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL check_cycle: valid=%b busy=%b, expected valid=0 busy=1", tx_data_valid, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'h1C) begin
            n_fail++;
            $display("FAIL first_byte_latency: valid=%b tx_data=%h, expected valid=1 tx_data=1c", tx_data_valid, tx_data);
        end
        recv_frame(0, 48, n);
        n_checks++;
        if (n != 48) begin
            n_fail++;
            $display("FAIL valid_length: got %0d bytes, expected 48", n);
        end
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (rsp[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL valid_byte[%0d]: got %h, expected %h", i, rsp[i], exp_b[i]);
            end
        end
        n_checks++;
        if (served !== 1'b1 || tx_data_valid !== 1'b0 || req_count !== 16'd1) begin
            n_fail++;
            $display("FAIL served_pulse: served=%b valid=%b req_count=%0d, expected 1 0 1", served, tx_data_valid, req_count);
        end
        @(posedge clk); #1;
        n_checks++;
        if (served !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL served_one_cycle: served=%b busy=%b, expected 0 0", served, busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        local_time = 32'h66DE0000; time_valid = 1'b1;
        make_req(8'hDB, 8'h00);
        build_exp(8'h1C, 32'hEA880E00);
        send_bytes(0, 48);
        recv_frame(0, 5, n);
        tx_data_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (tx_data !== exp_b[5] || tx_data_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: tx_data=%h valid=%b, expected %h valid=1", c, tx_data, tx_data_valid, exp_b[5]);
            end
        end
        recv_frame(5, 48, n);
        n_checks++;
        if (n != 48) begin
            n_fail++;
            $display("FAIL backpressure_length: got %0d bytes, expected 48", n);
        end
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (rsp[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL backpressure_byte[%0d]: got %h, expected %h", i, rsp[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reject();
        bit seen;
        do_reset();
        local_time = 32'h66DE0000; time_valid = 1'b1;
        make_req(8'h1C, 8'h00);
        send_bytes(0, 48);
        watch_quiet(60, seen);
        n_checks++;
        if (seen || rej_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reject_mode: tx seen=%b rej_count=%0d, expected seen=0 rej_count=1", seen, rej_count);
        end
        make_req(8'hDB, 8'h00);
        time_valid = 1'b0;
        send_bytes(0, 48);
        watch_quiet(60, seen);
        n_checks++;
        if (seen || rej_count !== 8'd2 || req_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reject_time_invalid: tx seen=%b rej_count=%0d req_count=%0d, expected 0 2 0", seen, rej_count, req_count);
        end
        time_valid = 1'b1;
    endtask

    task automatic test_gap();
        int n;
        bit seen;
        do_reset();
        local_time = 32'h66DE0000; time_valid = 1'b1;
        make_req(8'hDB, 8'h00);
        build_exp(8'h1C, 32'hEA880E00);
        send_bytes(0, 20);
        repeat (1100) @(posedge clk);
        #1;
        n_checks++;
        if (rej_count !== 8'd1 || tx_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_abort: rej_count=%0d valid=%b, expected 1 0", rej_count, tx_data_valid);
        end
        send_bytes(0, 48);
        recv_frame(0, 48, n);
        n_checks++;
        if (n != 48) begin
            n_fail++;
            $display("FAIL gap_reply_length: got %0d bytes, expected 48", n);
        end
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (rsp[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL gap_byte[%0d]: got %h, expected %h", i, rsp[i], exp_b[i]);
            end
        end
        watch_quiet(100, seen);
        n_checks++;
        if (seen || req_count !== 16'd1 || rej_count !== 8'd1) begin
            n_fail++;
            $display("FAIL gap_single_reply: extra tx=%b req_count=%0d rej_count=%0d, expected 0 1 1", seen, req_count, rej_count);
        end
    endtask

    task automatic test_gap_boundary();
        int n;
        do_reset();
        local_time = 32'h66DE0000; time_valid = 1'b1;
        make_req(8'hDB, 8'h00);
        send_bytes(0, 1);
        repeat (999) @(posedge clk);
        #1;
        send_bytes(1, 48);
        recv_frame(0, 48, n);
        n_checks++;
        if (n != 48 || rej_count !== 8'd0 || req_count !== 16'd1) begin
            n_fail++;
            $display("FAIL gap_byte_wins: bytes=%0d rej_count=%0d req_count=%0d, expected 48 0 1", n, rej_count, req_count);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        local_time = 32'h80000000; time_valid = 1'b1;
        make_req(8'hDB, 8'h5A);
        build_exp(8'h1C, 32'h03AA0E00);
        send_bytes(0, 48);
        @(posedge clk); #1;
        local_time = 32'h12345678;
        recv_frame(0, 48, n);
        n_checks++;
        if (n != 48) begin
            n_fail++;
            $display("FAIL wrap_length: got %0d bytes, expected 48", n);
        end
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (rsp[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL wrap_byte[%0d]: got %h, expected %h", i, rsp[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        do_reset();
        local_time = 32'h66DE0000; time_valid = 1'b1;
        make_req(8'hDB, 8'h00);
        build_exp(8'h1C, 32'hEA880E00);
        send_bytes(0, 48);
        recv_frame(0, 20, n);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (n != 20 || tx_data_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_send: bytes=%0d valid=%b busy=%b, expected 20 0 0", n, tx_data_valid, busy);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_bytes(0, 48);
        recv_frame(0, 48, n);
        n_checks++;
        if (n != 48 || req_count !== 16'd1) begin
            n_fail++;
            $display("FAIL after_reset_reply: bytes=%0d req_count=%0d, expected 48 1", n, req_count);
        end
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (rsp[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL after_reset_byte[%0d]: got %h, expected %h", i, rsp[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0; tx_data_ready = 1'b1;
        local_time = 32'd0; time_valid = 1'b0;
        test_reset();
        test_valid();
        test_backpressure();
        test_reject();
        test_gap();
        test_gap_boundary();
        test_wrap();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
